// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the adder tree and its downstream accumulator.
package adder_tree_pkg;

  typedef logic [31:0] fp32_t;

  localparam int unsigned TREE_LATENCY_DEFAULT = 6;

  // ceil(log2(n)) pairwise levels; a tree over n elements has latency tree_levels(n) + 1.
  function automatic int unsigned tree_levels(input int unsigned n);
    int unsigned lv;
    lv = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) lv = i + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/acc_result_fifo.sv
// Small circular result FIFO with registered head; push and pop may coincide at any fill level.
module acc_result_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_DEPTH  = 2,
  localparam int unsigned CNT_W     = $clog2(OUT_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(OUT_DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/float_add.sv
// Single-cycle combinational fp32 adder, round-to-nearest-even, subnormals flushed to zero.
module float_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  logic [31:0] w_big, w_small, w_pack;
  logic [7:0]  w_eb, w_es, w_shift;
  logic [26:0] w_mb, w_ms, w_norm;
  logic [27:0] w_raw;
  logic [9:0]  w_e;
  logic        w_sub, w_up;
  int unsigned w_lz;

  always_comb begin
    o_sum   = '0;
    w_big   = i_a;
    w_small = i_b;
    w_mb    = '0;
    w_ms    = '0;
    w_norm  = '0;
    w_raw   = '0;
    w_e     = '0;
    w_up    = 1'b0;
    w_pack  = '0;
    w_lz    = 0;
    if (i_a[30:0] < i_b[30:0]) begin
      w_big   = i_b;
      w_small = i_a;
    end
    w_eb    = w_big[30:23];
    w_es    = w_small[30:23];
    w_sub   = w_big[31] ^ w_small[31];
    w_shift = w_eb - w_es;
    if (w_eb == 8'hFF) begin
      if (w_big[22:0] != '0) o_sum = w_big | 32'h0040_0000;
      else if (w_es == 8'hFF && w_sub) o_sum = 32'h7FC0_0000;
      else o_sum = w_big;
    end else if (w_es == 8'h00) begin
      if (w_eb == 8'h00) o_sum = {w_big[31] & w_small[31], 31'd0};
      else o_sum = w_big;
    end else begin
      w_mb = {1'b1, w_big[22:0], 3'b000};
      w_ms = {1'b1, w_small[22:0], 3'b000};
      // Three extra bits carry guard, round and sticky through alignment.
      if (w_shift >= 8'd27) w_ms = 27'd1;
      else w_ms = (w_ms >> w_shift) | {26'd0, |(w_ms & ~({27{1'b1}} << w_shift))};
      w_raw = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms}) : ({1'b0, w_mb} + {1'b0, w_ms});
      w_e   = {2'b00, w_eb};
      if (w_raw[27]) begin
        w_norm = w_raw[27:1] | {26'd0, w_raw[0]};
        w_e    = w_e + 10'd1;
      end else begin
        w_lz = 27;
        for (int i = 0; i < 27; i++) begin
          if (w_raw[i]) w_lz = 26 - i;
        end
        w_norm = w_raw[26:0] << w_lz;
        w_e    = w_e - 10'(w_lz);
      end
      if (w_raw == '0) begin
        o_sum = '0;
      end else if (w_e[9] || w_e == '0) begin
        o_sum = {w_big[31], 31'd0};
      end else begin
        w_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        // Hidden bit lands on the exponent LSB, so a rounding carry bumps the exponent for free.
        w_pack = {w_e[8:0] - 9'd1, 23'd0} + {8'd0, w_norm[26:3]} + {31'd0, w_up};
        if (w_pack[31] || w_pack[30:23] == 8'hFF) o_sum = {w_big[31], 8'hFF, 23'd0};
        else o_sum = {w_big[31], w_pack[30:0]};
      end
    end
  end

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates NUM_CHUNKS consecutive tree sums per frame and queues frame results,
// throttling the producer by frame credits so the result FIFO cannot overflow.
module adder_tree_accumulator
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TREE_LATENCY = TREE_LATENCY_DEFAULT,
  parameter int unsigned NUM_CHUNKS   = 4,
  parameter int unsigned OUT_DEPTH    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_tree_s,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_busy
);

  localparam int unsigned CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  logic [TREE_LATENCY-1:0] r_vld_pipe;
  logic [CHUNK_W-1:0]      r_cnt, r_in_cnt;
  logic [CNT_W-1:0]        r_outstanding, w_fifo_count;
  fp32_t                   r_acc, w_sum, w_push_data;
  logic w_accept, w_s_vld, w_last, w_push, w_pop, w_frame_start, w_fifo_full, w_fifo_empty;

  assign w_accept      = i_in_valid & o_in_ready;
  assign w_frame_start = w_accept & (r_in_cnt == '0);
  assign w_s_vld       = r_vld_pipe[TREE_LATENCY-1];
  assign w_last        = (r_cnt == LAST_CHUNK);
  // First chunk loads directly so a lone -0.0 survives instead of becoming +0.0.
  assign w_push_data   = (r_cnt == '0) ? i_tree_s : w_sum;
  assign w_push        = w_s_vld & w_last & (~w_fifo_full | w_pop);
  assign w_pop         = o_out_valid & i_out_ready;

  // A frame already open at the input must be allowed to finish; its credit is already taken.
  assign o_in_ready  = (r_outstanding < CNT_W'(OUT_DEPTH)) | (r_in_cnt != '0);
  assign o_out_valid = ~w_fifo_empty;
  assign o_busy      = (|r_vld_pipe) | (r_cnt != '0) | (w_fifo_count != '0);

  float_add u_float_add (
    .i_a   (r_acc),
    .i_b   (i_tree_s),
    .o_sum (w_sum)
  );

  acc_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count),
    .o_head  (o_out_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe    <= '0;
      r_cnt         <= '0;
      r_in_cnt      <= '0;
      r_acc         <= '0;
      r_outstanding <= '0;
    end else begin
      r_vld_pipe[0] <= w_accept;
      for (int i = 1; i < TREE_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_accept) r_in_cnt <= (r_in_cnt == LAST_CHUNK) ? '0 : r_in_cnt + CHUNK_W'(1);
      if (w_s_vld) begin
        r_cnt <= w_last ? '0 : r_cnt + CHUNK_W'(1);
        r_acc <= w_push_data;
      end
      unique case ({w_frame_start, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Scoreboard bench: a delay line stands in for the adder tree; frame sums are queued when driven.
module tb_adder_tree_accumulator;

  localparam int TL = 6;

  logic        clk, rst_n;
  logic [31:0] s_in, tree_s;
  logic [31:0] tree_dly [TL];
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [31:0] out_data0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0] out_data1;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_t = 0;
  int          valid_cycles0 = 0;
  int          snap;

  adder_tree_accumulator #(
    .DATA_WIDTH(32), .TREE_LATENCY(TL), .NUM_CHUNKS(4), .OUT_DEPTH(2)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid0), .o_in_ready(in_ready0),
    .i_tree_s(tree_s), .o_out_valid(out_valid0), .i_out_ready(out_ready0),
    .o_out_data(out_data0), .o_busy(busy0)
  );

  adder_tree_accumulator #(
    .DATA_WIDTH(32), .TREE_LATENCY(TL), .NUM_CHUNKS(1), .OUT_DEPTH(2)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid1), .o_in_ready(in_ready1),
    .i_tree_s(tree_s), .o_out_valid(out_valid1), .i_out_ready(out_ready1),
    .o_out_data(out_data1), .o_busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tree_dly[0] <= s_in;
    for (int i = 1; i < TL; i++) tree_dly[i] <= tree_dly[i-1];
  end
  assign tree_s = tree_dly[TL-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      valid_cycles0 <= valid_cycles0 + 1;
      if (out_ready0) begin
        if (q0.size() == 0) check_eq("dut0_extra_frame", 32'(q0.size()), 32'd1);
        else check_eq("dut0_data", out_data0, q0.pop_front());
      end
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check_eq("dut1_extra_frame", 32'(q1.size()), 32'd1);
      else check_eq("dut1_data", out_data1, q1.pop_front());
    end
  end

  task automatic send_beat(input logic [31:0] v);
    int n;
    n = 0;
    in_valid0 = 1'b1;
    s_in = v;
    @(negedge clk);
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) check_eq("accept_timeout", 32'(in_ready0), 32'd1);
    last_t = cyc;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    s_in = $urandom;
  endtask

  task automatic send_frame(input logic [127:0] vals, input int gap, input logic [31:0] exp);
    q0.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      send_beat(vals[32*i +: 32]);
      if (i < 3) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(cyc - last_t), 32'd7);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b1; out_ready1 = 1'b1;
    s_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready0), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid0), 32'd0);
    check_eq("rst_out_data", out_data0, 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_in_ready1", 32'(in_ready1), 32'd1);
    check_eq("rst_out_valid1", 32'(out_valid1), 32'd0);
    @(posedge clk);
    #1;

    // 1.0+2.0+3.0+4.0 back-to-back
    send_frame({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 0, 32'h41200000);
    wait_out("t1_latency");
    repeat (3) @(posedge clk);
    #1;

    // same frame with bubbles between chunks
    send_frame({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 3, 32'h41200000);
    @(negedge clk);
    check_eq("t2_busy", 32'(busy0), 32'd1);
    wait_out("t2_latency");
    repeat (3) @(posedge clk);
    #1;

    // back-pressure: two frames fill the FIFO, the third waits for a pop
    out_ready0 = 1'b0;
    send_frame({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 0, 32'h41200000);
    send_frame({4{32'h3F800000}}, 0, 32'h40800000);
    repeat (12) @(negedge clk);
    check_eq("t3_out_valid", 32'(out_valid0), 32'd1);
    check_eq("t3_head_stable", out_data0, 32'h41200000);
    check_eq("t3_in_ready_low", 32'(in_ready0), 32'd0);
    check_eq("t3_busy", 32'(busy0), 32'd1);
    fork
      send_frame({4{32'h40000000}}, 0, 32'h41000000);
      begin
        repeat (5) @(negedge clk);
        check_eq("t3_still_blocked", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1 out_ready0 = 1'b1;
      end
    join
    repeat (15) @(negedge clk);
    check_eq("t3_drained", 32'(q0.size()), 32'd0);
    @(posedge clk);
    #1;

    // reset with two chunks in flight must not emit anything
    snap = valid_cycles0;
    send_beat(32'h3F800000);
    send_beat(32'h3F800000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check_eq("t4_no_valid", 32'(valid_cycles0 - snap), 32'd0);
    check_eq("t4_busy", 32'(busy0), 32'd0);
    check_eq("t4_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1;
    send_frame({4{32'h3F800000}}, 0, 32'h40800000);
    wait_out("t4_latency");
    repeat (3) @(posedge clk);
    #1;

    // push and pop land on the same edge; nothing lost, order kept
    out_ready0 = 1'b0;
    send_frame({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 0, 32'h41200000);
    send_frame({4{32'h3F800000}}, 0, 32'h40800000);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready0 = 1'b1;
    @(posedge clk);
    #1 out_ready0 = 1'b0;
    send_frame({4{32'h40000000}}, 0, 32'h41000000);
    repeat (5) @(posedge clk);
    #1 out_ready0 = 1'b1;
    @(posedge clk);
    #1 out_ready0 = 1'b0;
    @(negedge clk);
    check_eq("t5_valid_after_swap", 32'(out_valid0), 32'd1);
    check_eq("t5_head_after_swap", out_data0, 32'h41000000);
    @(posedge clk);
    #1 out_ready0 = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t5_drained", 32'(q0.size()), 32'd0);
    check_eq("t5_empty", 32'(out_valid0), 32'd0);

    // single-chunk frames pass S straight through, including -0.0
    @(posedge clk);
    #1;
    q1.push_back(32'h80000000);
    s_in = 32'h80000000;
    in_valid1 = 1'b1;
    @(negedge clk);
    check_eq("t6_in_ready1", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1;
    q1.push_back(32'hC0400000);
    s_in = 32'hC0400000;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    s_in = $urandom;
    repeat (14) @(negedge clk);
    check_eq("t6_drained", 32'(q1.size()), 32'd0);
    check_eq("end_busy0", 32'(busy0), 32'd0);
    check_eq("end_busy1", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
